// File: rtl/fft_pkg.sv
// fft_pkg -- shared constants and types for the FFT stage sequencer.
//   NUM/DATA/BLOCKS : lanes per beat, samples per frame, beats per frame
//   BLK_W           : width of a beat index within a frame
//   HALF_SPAN       : beats per butterfly half-span (power of two)
//   SEL_DLY/TW_DLY/LAT : taps of the flag delay line (butterfly select,
//                     twiddle index, stage output)
//   stage_state_e   : sequencer state (IDLE, RUN, DRAIN)
package fft_pkg;

   localparam int NUM       = 16;
   localparam int DATA      = 512;
   localparam int BLOCKS    = DATA / NUM;
   localparam int BLK_W     = $clog2(BLOCKS);
   localparam int HALF_SPAN = 4;
   localparam int SEL_BIT   = $clog2(HALF_SPAN);
   localparam int SEL_DLY   = 1;
   localparam int TW_DLY    = 3;
   localparam int LAT       = 4;
   // Drain counter only has to reach LAT-1.
   localparam int DRN_W     = $clog2(LAT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } stage_state_e;

endpackage

// File: rtl/fft_flag_dly.sv
// fft_flag_dly -- fixed-depth register delay line, every stage clears to 0.
//   clk   in   clock
//   rstn  in   asynchronous active-low reset
//   din   in   WIDTH-bit value entering the line
//   dout  out  din delayed by DEPTH clock cycles (DEPTH >= 1)
module fft_flag_dly #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [DEPTH-1:0][WIDTH-1:0] pipe_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pipe_reg <= '0;
      end else begin
         pipe_reg[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_reg[i] <= pipe_reg[i-1];
         end
      end
   end

   assign dout = pipe_reg[DEPTH-1];

endmodule

// File: rtl/fft_stage_seq.sv
// fft_stage_seq -- sequencer for one radix-2 butterfly + twiddle stage of the
// 16-lane, 512-point FFT. Tracks the beat index within each frame and emits
// control/markers aligned to the stage pipeline.
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   valid_in   in   input beat valid
//   sof_in     in   first beat of frame (qualified by valid_in)
//   bf_sel     out  1 = butterfly low output, 0 = delayed high output
//   tw_blk     out  twiddle block index (ROM index = lane + tw_blk*NUM)
//   tw_en      out  tw_blk valid this cycle
//   valid_out  out  stage output valid
//   sof_out    out  first output beat of frame
//   eof_out    out  last output beat of frame
//   frame_err  out  one-cycle malformed-frame pulse
//   frame_cnt  out  (FFT_STAGE_SEQ_STATS_EN only) completed frames, wraps
//   err_cnt    out  (FFT_STAGE_SEQ_STATS_EN only) frame errors, saturates
//   busy       out  frame in progress or pipeline draining
// Optional statistics outputs are built when FFT_STAGE_SEQ_STATS_EN is defined.
module fft_stage_seq
   import fft_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             valid_in,
   input  logic             sof_in,
   output logic             bf_sel,
   output logic [BLK_W-1:0] tw_blk,
   output logic             tw_en,
   output logic             valid_out,
   output logic             sof_out,
   output logic             eof_out,
   output logic             frame_err,
`ifdef FFT_STAGE_SEQ_STATS_EN
   output logic [15:0]      frame_cnt,
   output logic [7:0]       err_cnt,
`endif
   output logic             busy
);

   stage_state_e     state_reg;
   logic [DRN_W-1:0] drain_cnt_reg;
   logic [BLK_W-1:0] blk_cnt_reg;
   logic             frame_err_reg;
   logic             bf_hold_reg;

   logic [BLK_W-1:0] idx;
   logic             beat_first;
   logic             beat_last;
   logic             err_next;

   // sof_in forces index 0 (legal at a boundary, early SOF otherwise).
   assign idx        = sof_in ? '0 : blk_cnt_reg;
   assign beat_first = valid_in & (idx == '0);
   assign beat_last  = valid_in & (idx == BLK_W'(BLOCKS - 1));
   // Truncation (gap mid-frame) or early SOF: both need a frame in progress.
   assign err_next   = (blk_cnt_reg != '0) & (~valid_in | sof_in);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         blk_cnt_reg   <= '0;
         frame_err_reg <= 1'b0;
      end else begin
         // BLOCKS is a power of two, so the natural wrap is the modulo.
         blk_cnt_reg   <= valid_in ? idx + BLK_W'(1) : '0;
         frame_err_reg <= err_next;
      end
   end

   // DRAIN is entered after the first idle cycle, so that cycle already
   // counts toward the LAT idle cycles needed to return to IDLE.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg     <= IDLE;
         drain_cnt_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (valid_in) state_reg <= RUN;
            end
            RUN: begin
               if (!valid_in) begin
                  state_reg     <= DRAIN;
                  drain_cnt_reg <= DRN_W'(1);
               end
            end
            DRAIN: begin
               if (valid_in) begin
                  state_reg <= RUN;
               end else if (drain_cnt_reg == DRN_W'(LAT - 1)) begin
                  state_reg <= IDLE;
               end else begin
                  drain_cnt_reg <= drain_cnt_reg + DRN_W'(1);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Butterfly select tap: {valid, select bit}.
   logic [1:0] sel_tap;
   fft_flag_dly #(.DEPTH(SEL_DLY), .WIDTH(2)) u_sel_dly (
      .clk  (clk),
      .rstn (rstn),
      .din  ({valid_in, idx[SEL_BIT]}),
      .dout (sel_tap)
   );

   // Twiddle tap: {valid, idx}; idx is zeroed on idle cycles.
   logic [BLK_W:0] tw_tap;
   fft_flag_dly #(.DEPTH(TW_DLY), .WIDTH(BLK_W + 1)) u_tw_dly (
      .clk  (clk),
      .rstn (rstn),
      .din  ({valid_in, (valid_in ? idx : {BLK_W{1'b0}})}),
      .dout (tw_tap)
   );

   // Output tap: {valid, sof, eof}.
   logic [2:0] lat_tap;
   fft_flag_dly #(.DEPTH(LAT), .WIDTH(3)) u_lat_dly (
      .clk  (clk),
      .rstn (rstn),
      .din  ({valid_in, beat_first, beat_last}),
      .dout (lat_tap)
   );

   // bf_sel keeps its last value while no beat is in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bf_hold_reg <= 1'b0;
      end else begin
         bf_hold_reg <= bf_sel;
      end
   end

   assign bf_sel    = sel_tap[1] ? sel_tap[0] : bf_hold_reg;
   assign tw_en     = tw_tap[BLK_W];
   assign tw_blk    = tw_tap[BLK_W-1:0];
   assign valid_out = lat_tap[2];
   assign sof_out   = lat_tap[1];
   assign eof_out   = lat_tap[0];
   assign frame_err = frame_err_reg;
   assign busy      = (state_reg != IDLE);

`ifdef FFT_STAGE_SEQ_STATS_EN
   logic [15:0] frame_cnt_reg;
   logic [7:0]  err_cnt_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         frame_cnt_reg <= '0;
         err_cnt_reg   <= '0;
      end else begin
         if (eof_out) frame_cnt_reg <= frame_cnt_reg + 16'd1;
         if (frame_err_reg && (err_cnt_reg != 8'hFF)) err_cnt_reg <= err_cnt_reg + 8'd1;
      end
   end

   assign frame_cnt = frame_cnt_reg;
   assign err_cnt   = err_cnt_reg;
`endif

endmodule
